// File: rtl/sink_pkg.sv
// Shared types and constants for the sink receiver: FSM state encoding,
// the first value of the expected data sequence, and a next-state helper.
package sink_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        DELAY  = 3'b010,
        ACCEPT = 3'b100
    } sink_state_t;

    // First data word the source produces after reset.
    localparam int SEQ_START = 1;

    // State to enter when leaving IDLE or completing an accept: a zero delay
    // keeps ready up, anything else starts an idle wait.
    function automatic sink_state_t wait_state(input logic delay_zero);
        sink_state_t st;
        if (delay_zero) begin
            st = ACCEPT;
        end else begin
            st = DELAY;
        end
        return st;
    endfunction

endpackage

// File: rtl/sink_if.sv
// valid_ready bus: single-word transfer when valid and ready are both high
// at a rising clock edge. The master drives valid/data, the slave drives ready.
interface valid_ready #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport Master (output valid, output data, input ready);
    modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/sink_delay_ctr.sv
// Idle-wait timer for the sink. A load captures the wait length and restarts
// the count; done_o is registered and is high during the last wait cycle, so
// the controlling FSM can leave its wait state on that edge.
module sink_delay_ctr #(
    parameter int DELAY_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [DELAY_BITS-1:0] delay_i,
    input  logic                  en_i,
    output logic                  done_o
);
    localparam int EW = DELAY_BITS + 1;

    logic [DELAY_BITS-1:0] delay_q, delay_d;
    logic [DELAY_BITS-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;

    // Next-state: load restarts at zero, enable advances the count; done is
    // precomputed so it is high exactly when cnt+1 equals the loaded delay.
    always_comb begin
        delay_d = delay_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (load_i) begin
            delay_d = delay_i;
            cnt_d   = {DELAY_BITS{1'b0}};
            done_d  = ({1'b0, delay_i} == EW'(1));
        end else if (en_i) begin
            cnt_d   = cnt_q + DELAY_BITS'(1);
            done_d  = (({1'b0, cnt_q} + EW'(2)) == {1'b0, delay_q});
        end else begin
            done_d  = done_q;
        end
    end

    // Timer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            delay_q <= {DELAY_BITS{1'b0}};
            cnt_q   <= {DELAY_BITS{1'b0}};
            done_q  <= 1'b0;
        end else begin
            delay_q <= delay_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/sink.sv
// sink: receiving end of the valid_ready bus. Raises ready after a
// programmable idle delay, accepts one word per handshake, counts accepts
// and (optionally) checks the incrementing 1,2,3,... data sequence.
// Optional feature macro: SINK_SEQ_CHECK_EN enables the sequence checker;
// without it err_count and seq_error are tied to zero.
module sink
    import sink_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DELAY_BITS  = 3,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DELAY_BITS-1:0]  delay,
    valid_ready.Slave              vrBus,
    output logic [COUNT_WIDTH-1:0] rx_count,
    output logic [COUNT_WIDTH-1:0] err_count,
    output logic [DATA_WIDTH-1:0]  last_data,
    output logic                   seq_error
);
    sink_state_t state_q;
    logic        ready_q;
    logic        handshake_s;
    logic        delay_zero_s;
    logic        load_s;
    logic        wait_en_s;
    logic        wait_done_s;

    logic [COUNT_WIDTH-1:0] rx_count_q, rx_count_d;
    logic [DATA_WIDTH-1:0]  last_data_q, last_data_d;

    assign handshake_s  = vrBus.valid & ready_q;
    assign delay_zero_s = (delay == {DELAY_BITS{1'b0}});
    // The delay input is only captured when a wait actually starts.
    assign load_s       = ((state_q == IDLE) | ((state_q == ACCEPT) & handshake_s)) & ~delay_zero_s;
    assign wait_en_s    = (state_q == DELAY);

    sink_delay_ctr #(
        .DELAY_BITS (DELAY_BITS)
    ) u_delay_ctr (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load_s),
        .delay_i (delay),
        .en_i    (wait_en_s),
        .done_o  (wait_done_s)
    );

    // Control FSM; ready is a registered copy of "next state is ACCEPT".
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= wait_state(delay_zero_s);
                    ready_q <= delay_zero_s;
                end
                DELAY: begin
                    if (wait_done_s) begin
                        state_q <= ACCEPT;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= DELAY;
                        ready_q <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (handshake_s) begin
                        state_q <= wait_state(delay_zero_s);
                        ready_q <= delay_zero_s;
                    end else begin
                        state_q <= ACCEPT;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign vrBus.ready = ready_q;

    // Accept bookkeeping: capture data and bump the wrapping receive count.
    always_comb begin
        rx_count_d  = rx_count_q;
        last_data_d = last_data_q;
        if (handshake_s) begin
            rx_count_d  = rx_count_q + COUNT_WIDTH'(1);
            last_data_d = vrBus.data;
        end else begin
            rx_count_d  = rx_count_q;
            last_data_d = last_data_q;
        end
    end

    // Accept bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_count_q  <= {COUNT_WIDTH{1'b0}};
            last_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            rx_count_q  <= rx_count_d;
            last_data_q <= last_data_d;
        end
    end

    assign rx_count  = rx_count_q;
    assign last_data = last_data_q;

`ifdef SINK_SEQ_CHECK_EN
    logic [DATA_WIDTH-1:0]  expected_q, expected_d;
    logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                   seq_error_q, seq_error_d;
    logic                   mismatch_s;

    assign mismatch_s = handshake_s & (vrBus.data != expected_q);

    // Sequence checker: resync expected to data+1 on every accept, count
    // mismatches with saturation and pulse seq_error for one cycle.
    always_comb begin
        expected_d  = expected_q;
        err_count_d = err_count_q;
        seq_error_d = mismatch_s;
        if (handshake_s) begin
            expected_d = vrBus.data + DATA_WIDTH'(1);
        end else begin
            expected_d = expected_q;
        end
        if (mismatch_s && (err_count_q != {COUNT_WIDTH{1'b1}})) begin
            err_count_d = err_count_q + COUNT_WIDTH'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Sequence checker registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            expected_q  <= DATA_WIDTH'(SEQ_START);
            err_count_q <= {COUNT_WIDTH{1'b0}};
            seq_error_q <= 1'b0;
        end else begin
            expected_q  <= expected_d;
            err_count_q <= err_count_d;
            seq_error_q <= seq_error_d;
        end
    end

    assign err_count = err_count_q;
    assign seq_error = seq_error_q;
`else
    assign err_count = {COUNT_WIDTH{1'b0}};
    assign seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_sink.sv
// Self-checking bench for sink: a driver offers words and pushes the
// expected accept results into a scoreboard; a monitor pops on every
// observed handshake and also predicts the ready waveform from the delay rules.
module tb_sink;
    localparam int DW = 8;
    localparam int DB = 3;
    localparam int CW = 16;
`ifdef SINK_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DB-1:0] delay = '0;
    logic [CW-1:0] rx_count, err_count;
    logic [DW-1:0] last_data;
    logic          seq_error;

    valid_ready #(.DATA_WIDTH(DW)) vr ();

    sink #(.DATA_WIDTH(DW), .DELAY_BITS(DB), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .delay     (delay),
        .vrBus     (vr),
        .rx_count  (rx_count),
        .err_count (err_count),
        .last_data (last_data),
        .seq_error (seq_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] rx;
        logic [CW-1:0] err;
        logic          serr;
    } exp_t;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] m_next = 8'd1;
    logic [CW-1:0] m_rx   = '0;
    logic [CW-1:0] m_err  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model of one accepted word, evaluated when the word is offered.
    task automatic push(input logic [DW-1:0] d);
        exp_t e;
        e.serr = CHK && (d != m_next);
        if (e.serr && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_rx   = m_rx + 16'd1;
        m_next = d + 8'd1;
        e.data = d;
        e.rx   = m_rx;
        e.err  = m_err;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sb_q.delete();
        m_next = 8'd1;
        m_rx   = '0;
        m_err  = '0;
        repeat (n) tick();
        reset = 1'b0;
        vr.valid = 1'b0;
    endtask

    // Offer one word until accepted; optionally disturb delay during the wait.
    task automatic send(input logic [DW-1:0] d, input bit jitter);
        bit hs;
        push(d);
        vr.valid = 1'b1;
        vr.data  = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            hs = (vr.ready === 1'b1);
            tick();
            if (hs) begin
                vr.valid = 1'b0;
                return;
            end
            if (jitter && ($urandom_range(0, 2) == 0)) delay = DB'($urandom_range(0, 7));
        end
        check("accept_timeout", 32'd0, 32'd1);
        vr.valid = 1'b0;
    endtask

    // Monitor: predicts ready from the delay rules and pops the scoreboard.
    initial begin : monitor
        bit            armed = 1'b0;
        bit            s_rst, s_hs, s_valid;
        logic [DB-1:0] s_d;
        bit            exp_ready = 1'b0;
        bit            fresh = 1'b0;
        int            wait_left = 0;
        logic [CW-1:0] cur_rx = '0, cur_err = '0;
        logic [DW-1:0] cur_last = '0;
        logic          exp_serr;
        exp_t          e;
        forever begin
            @(negedge clk);
            s_rst   = reset;
            s_valid = (vr.valid === 1'b1);
            s_hs    = s_valid && (vr.ready === 1'b1);
            s_d     = delay;
            if (s_rst) armed = 1'b1;
            // ready prediction for the cycle after the coming edge
            if (s_rst) begin
                exp_ready = 1'b0; fresh = 1'b1; wait_left = 0;
            end else if (fresh) begin
                fresh = 1'b0;
                if (s_d == 0) exp_ready = 1'b1;
                else begin exp_ready = 1'b0; wait_left = int'(s_d); end
            end else if (wait_left > 0) begin
                wait_left--;
                if (wait_left == 0) exp_ready = 1'b1;
            end else if (exp_ready && s_valid) begin
                if (s_d != 0) begin exp_ready = 1'b0; wait_left = int'(s_d); end
            end
            @(posedge clk);
            #2;
            if (armed) begin
                if (s_rst) begin
                    cur_rx = '0; cur_err = '0; cur_last = '0;
                    check("rst_ready", 32'(vr.ready), 32'd0);
                    check("rst_rx_count", 32'(rx_count), 32'd0);
                    check("rst_err_count", 32'(err_count), 32'd0);
                    check("rst_last_data", 32'(last_data), 32'd0);
                    check("rst_seq_error", 32'(seq_error), 32'd0);
                end else begin
                    check("ready", 32'(vr.ready), 32'(exp_ready));
                    exp_serr = 1'b0;
                    if (s_hs) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_accept", 32'd1, 32'd0);
                        end else begin
                            e = sb_q.pop_front();
                            cur_rx = e.rx; cur_err = e.err; cur_last = e.data;
                            exp_serr = e.serr;
                        end
                    end
                    check("rx_count", 32'(rx_count), 32'(cur_rx));
                    check("err_count", 32'(err_count), 32'(cur_err));
                    check("last_data", 32'(last_data), 32'(cur_last));
                    check("seq_error", 32'(seq_error), 32'(exp_serr));
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin : stimulus
        logic [DW-1:0] d;
        vr.valid = 1'b0;
        vr.data  = '0;
        tick();
        // reset held two cycles with valid high; valid must not be taken
        vr.valid = 1'b1;
        vr.data  = 8'h55;
        do_reset(2);
        repeat (3) tick();

        // delay=3, words 1..4 offered back to back
        delay = 3'd3;
        for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0);
        repeat (5) tick();

        // delay=0, ten consecutive words after a fresh reset
        delay = 3'd0;
        do_reset(1);
        for (int i = 1; i <= 10; i++) send(DW'(i), 1'b0);
        tick();

        // sequence 1,2,5,6: one mismatch on 5 when checking is enabled
        do_reset(1);
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd5, 1'b0); send(8'd6, 1'b0);
        repeat (2) tick();

        // wrap FE,FF,00 then reset while waiting in DELAY
        send(8'hFE, 1'b0); send(8'hFF, 1'b0); send(8'h00, 1'b0);
        delay = 3'd5;
        send(8'h01, 1'b0);
        repeat (2) tick();
        do_reset(1);
        repeat (8) tick();

        // delay raised 2 -> 5 during a wait: current wait stays 2
        delay = 3'd2;
        do_reset(1);
        delay = 3'd0;
        repeat (2) tick();
        delay = 3'd2;
        send(8'd1, 1'b0);
        tick();
        delay = 3'd5;
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        repeat (7) tick();

        // randomized run: random delays, gaps, jumps and mid-wait delay changes
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0) delay = DB'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) d = DW'($urandom);
            else d = m_next;
            send(d, 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        repeat (12) tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "time limit");
    end

endmodule
